// File: rtl/serial_bus_pkg.sv
// Shared types and sizing helpers for the serial system-bus arbiter.
package serial_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    CONNECTED,
    CLEAN
  } arb_state_e;

  localparam int XFER_CYCLES_DEFAULT = 32;

  // Width of the slave-select field taken from the top of the address.
  function automatic int sel_width(input int n_slaves);
    return (n_slaves < 2) ? 1 : $clog2(n_slaves);
  endfunction

  // Counter wide enough for both the address phase and the data window.
  function automatic int cnt_width(input int addr_w, input int xfer_cycles);
    int max_v;
    max_v = (addr_w > xfer_cycles) ? addr_w : xfer_cycles;
    return $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection. The search starts one past the last
// granted index and wraps; the pointer only moves when a grant is taken.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

  localparam int IDX_W = (N < 2) ? 1 : $clog2(N);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_found;
  int               w_idx;

  // First requester after the pointer, wrapping modulo N.
  always_comb begin
    o_grant   = '0;
    w_win_idx = r_ptr;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_win_idx      = IDX_W'(w_idx);
        w_found        = 1'b1;
      end
    end
  end

  // Pointer holds the last owner; reset value gives index 0 top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= IDX_W'(N - 1);
    end else if (i_advance && w_found) begin
      r_ptr <= w_win_idx;
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// N-master / M-slave serial bus arbiter: round-robin grant, serial address
// decode with ack/nak, then a fixed-length routed data window.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int N_MASTERS   = 2,
  parameter int N_SLAVES    = 4,
  parameter int ADDR_W      = 5,
  parameter int XFER_CYCLES = XFER_CYCLES_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_mode,
  input  logic [N_MASTERS-1:0] m_wr_bus,
  input  logic [N_MASTERS-1:0] m_master_valid,
  input  logic [N_MASTERS-1:0] m_master_ready,
  output logic [N_MASTERS-1:0] m_grant,
  output logic [N_MASTERS-1:0] m_ack,
  output logic [N_MASTERS-1:0] m_rd_bus,
  output logic [N_MASTERS-1:0] m_slave_ready,
  output logic [N_MASTERS-1:0] m_slave_valid,
  output logic [N_SLAVES-1:0]  s_mode,
  output logic [N_SLAVES-1:0]  s_wr_bus,
  output logic [N_SLAVES-1:0]  s_master_valid,
  output logic [N_SLAVES-1:0]  s_master_ready,
  input  logic [N_SLAVES-1:0]  s_rd_bus,
  input  logic [N_SLAVES-1:0]  s_slave_ready,
  input  logic [N_SLAVES-1:0]  s_slave_valid
);

  localparam int SEL_W = sel_width(N_SLAVES);
  localparam int CNT_W = cnt_width(ADDR_W, XFER_CYCLES);

  arb_state_e           r_state;
  arb_state_e           w_state_next;
  logic [N_MASTERS-1:0] r_grant;
  logic [ADDR_W-1:0]    r_addr;
  logic [CNT_W-1:0]     r_count;
  logic [SEL_W-1:0]     r_sel;

  logic [N_MASTERS-1:0] w_rr_grant;
  logic                 w_advance;
  logic                 w_own_valid;
  logic                 w_own_wr;
  logic                 w_own_mode;
  logic                 w_own_ready;
  logic [ADDR_W-1:0]    w_addr_shift;
  logic [SEL_W-1:0]     w_sel_dec;
  logic                 w_sel_ok;
  logic                 w_last_bit;
  logic                 w_xfer_done;
  logic                 w_in_addr;
  logic                 w_conn;
  logic [N_SLAVES-1:0]  w_sel_oh;
  logic                 w_sl_rd;
  logic                 w_sl_ready;
  logic                 w_sl_valid;

  rr_arbiter #(
    .N(N_MASTERS)
  ) u_rr (
    .clk      (clk),
    .rst      (rst),
    .i_req    (m_master_valid),
    .i_advance(w_advance),
    .o_grant  (w_rr_grant)
  );

  assign w_advance    = (r_state == IDLE) && (|m_master_valid);
  assign w_own_valid  = |(m_master_valid & r_grant);
  assign w_own_wr     = |(m_wr_bus & r_grant);
  assign w_own_mode   = |(m_mode & r_grant);
  assign w_own_ready  = |(m_master_ready & r_grant);
  // Low ADDR_W bits of {addr, bit} is the MSB-first shift, valid for ADDR_W=1 too.
  assign w_addr_shift = ADDR_W'({r_addr, w_own_wr});
  assign w_sel_dec    = w_addr_shift[ADDR_W-1 -: SEL_W];
  assign w_sel_ok     = 32'(w_sel_dec) < 32'(N_SLAVES);
  assign w_last_bit   = (r_count == CNT_W'(ADDR_W - 1));
  assign w_xfer_done  = (r_count == CNT_W'(XFER_CYCLES - 1));
  assign w_in_addr    = (r_state == ADDR);
  assign w_conn       = (r_state == CONNECTED);

  // Next-state decode for the arbitration sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_advance) w_state_next = ADDR;
      ADDR:      if (w_own_valid && w_last_bit) w_state_next = w_sel_ok ? CONNECTED : CLEAN;
      CONNECTED: if (w_xfer_done) w_state_next = CLEAN;
      CLEAN:     w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant latch, address shift/decode and the shared phase counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant <= '0;
      r_addr  <= '0;
      r_count <= '0;
      r_sel   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_count <= '0;
          if (w_advance) r_grant <= w_rr_grant;
        end
        ADDR: begin
          // A low valid from the owner is a stall: nothing moves.
          if (w_own_valid) begin
            r_addr <= w_addr_shift;
            if (w_last_bit) begin
              r_count <= '0;
              r_sel   <= w_sel_dec;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        CONNECTED: begin
          if (w_xfer_done) r_count <= '0;
          else             r_count <= r_count + 1'b1;
        end
        CLEAN: begin
          r_grant <= '0;
          r_addr  <= '0;
          r_count <= '0;
          r_sel   <= '0;
        end
        default: begin
          r_grant <= '0;
        end
      endcase
    end
  end

  // Slave-side demux: only the selected slave sees traffic, and only once acked.
  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      assign w_sel_oh[gi]       = w_conn && (r_sel == SEL_W'(gi));
      assign s_mode[gi]         = w_sel_oh[gi] & w_own_mode;
      assign s_wr_bus[gi]       = w_sel_oh[gi] & w_own_wr;
      assign s_master_valid[gi] = w_sel_oh[gi] & w_own_valid;
      assign s_master_ready[gi] = w_sel_oh[gi] & w_own_ready;
    end
  endgenerate

  assign w_sl_rd    = |(s_rd_bus & w_sel_oh);
  assign w_sl_ready = |(s_slave_ready & w_sel_oh);
  assign w_sl_valid = |(s_slave_valid & w_sel_oh);

  // Master-side return path: only the owner's lines are ever driven.
  generate
    for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
      assign m_grant[gi]       = r_grant[gi];
      assign m_ack[gi]         = r_grant[gi] & w_conn;
      assign m_rd_bus[gi]      = r_grant[gi] & w_sl_rd;
      assign m_slave_ready[gi] = r_grant[gi] & (w_in_addr | w_sl_ready);
      assign m_slave_valid[gi] = r_grant[gi] & w_sl_valid;
    end
  endgenerate

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed scenarios with randomized background traffic, checked every cycle
// against a transaction-level reference model of the arbiter.
module tb_serial_bus_arbiter;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int XC = 32;
  localparam int SW = 2;

  localparam int PH_IDLE  = 0;
  localparam int PH_ADDR  = 1;
  localparam int PH_CONN  = 2;
  localparam int PH_CLEAN = 3;

  logic          clk;
  logic          rst;
  logic [NM-1:0] m_mode, m_wr_bus, m_master_valid, m_master_ready;
  logic [NM-1:0] m_grant, m_ack, m_rd_bus, m_slave_ready, m_slave_valid;
  logic [NS-1:0] s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic [NS-1:0] s_rd_bus, s_slave_ready, s_slave_valid;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase, owner, rr history, collected address bits.
  int ph = PH_IDLE;
  int owner = -1;
  int last_owner = NM - 1;
  int nbits = 0;
  int addr_acc = 0;
  int sel_m = 0;
  int conn_n = 0;

  serial_bus_arbiter #(
    .N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .XFER_CYCLES(XC)
  ) dut (
    .clk(clk), .rst(rst),
    .m_mode(m_mode), .m_wr_bus(m_wr_bus),
    .m_master_valid(m_master_valid), .m_master_ready(m_master_ready),
    .m_grant(m_grant), .m_ack(m_ack), .m_rd_bus(m_rd_bus),
    .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid),
    .s_mode(s_mode), .s_wr_bus(s_wr_bus),
    .s_master_valid(s_master_valid), .s_master_ready(s_master_ready),
    .s_rd_bus(s_rd_bus), .s_slave_ready(s_slave_ready), .s_slave_valid(s_slave_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (rst) begin
      ph = PH_IDLE; owner = -1; last_owner = NM - 1; nbits = 0; addr_acc = 0;
    end else begin
      case (ph)
        PH_IDLE: if (m_master_valid != '0) begin
          for (int k = 1; k <= NM; k++) begin
            if (owner < 0 && m_master_valid[(last_owner + k) % NM]) owner = (last_owner + k) % NM;
          end
          last_owner = owner; ph = PH_ADDR; nbits = 0; addr_acc = 0;
        end
        PH_ADDR: if (m_master_valid[owner]) begin
          addr_acc = addr_acc * 2 + int'(m_wr_bus[owner]);
          nbits++;
          if (nbits == AW) begin
            sel_m = addr_acc >> (AW - SW);
            conn_n = 0;
            ph = (sel_m < NS) ? PH_CONN : PH_CLEAN;
          end
        end
        PH_CONN: begin
          conn_n++;
          if (conn_n == XC) ph = PH_CLEAN;
        end
        default: begin
          ph = PH_IDLE; owner = -1;
        end
      endcase
    end
  endtask

  // Compare every output against what the model says the bus looks like now.
  task automatic check_all();
    logic [NM-1:0] e_grant, e_ack, e_rd, e_sr, e_sv;
    logic [NS-1:0] e_smode, e_swr, e_smv, e_smr;
    e_grant = '0; e_ack = '0; e_rd = '0; e_sr = '0; e_sv = '0;
    e_smode = '0; e_swr = '0; e_smv = '0; e_smr = '0;
    if (owner >= 0) e_grant[owner] = 1'b1;
    if (ph == PH_ADDR) e_sr[owner] = 1'b1;
    if (ph == PH_CONN) begin
      e_ack[owner]  = 1'b1;
      e_smode[sel_m] = m_mode[owner];
      e_swr[sel_m]   = m_wr_bus[owner];
      e_smv[sel_m]   = m_master_valid[owner];
      e_smr[sel_m]   = m_master_ready[owner];
      e_rd[owner]    = s_rd_bus[sel_m];
      e_sr[owner]    = s_slave_ready[sel_m];
      e_sv[owner]    = s_slave_valid[sel_m];
    end
    if (ph != PH_CLEAN) chk("m_grant", 32'(m_grant), 32'(e_grant));
    chk("m_ack", 32'(m_ack), 32'(e_ack));
    chk("m_rd_bus", 32'(m_rd_bus), 32'(e_rd));
    chk("m_slave_ready", 32'(m_slave_ready), 32'(e_sr));
    chk("m_slave_valid", 32'(m_slave_valid), 32'(e_sv));
    chk("s_mode", 32'(s_mode), 32'(e_smode));
    chk("s_wr_bus", 32'(s_wr_bus), 32'(e_swr));
    chk("s_master_valid", 32'(s_master_valid), 32'(e_smv));
    chk("s_master_ready", 32'(s_master_ready), 32'(e_smr));
  endtask

  // One clock: check at the falling edge, model on the rising edge, then new background.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
    m_mode         = NM'($urandom);
    m_master_ready = NM'($urandom);
    m_wr_bus       = NM'($urandom);
    s_rd_bus       = NS'($urandom);
    s_slave_ready  = NS'($urandom);
    s_slave_valid  = NS'($urandom);
  endtask

  // Full transaction from master m: request, address (optional stall), window.
  task automatic run_xfer(input int m, input logic [AW-1:0] addr, input int stall_at,
                          input bit rd_toggle, input int abort_after);
    int guard;
    logic [AW-1:0] a;
    logic [2:0] pat;
    a = addr;
    pat = 3'b101;
    m_master_valid[m] = 1'b1;
    guard = 0;
    while (!(ph == PH_ADDR && owner == m) && guard < 50) begin tick(); guard++; end
    chk("grant_wait_timeout", 32'(guard >= 50), 0);
    chk("grant_onehot", 32'(m_grant), 32'(1 << m));
    for (int b = AW - 1; b >= 0; b--) begin
      if (stall_at >= 0 && b == AW - 1 - stall_at) begin
        m_master_valid[m] = 1'b0;
        repeat (3) tick();
        m_master_valid[m] = 1'b1;
      end
      m_wr_bus[m] = a[b];
      tick();
    end
    chk("ack_after_addr", 32'(m_ack), (32'(a >> (AW - SW)) < NS) ? 32'(1 << m) : 0);
    if (rd_toggle) begin
      for (int i = 2; i >= 0; i--) begin
        s_rd_bus[2] = pat[i];
        #1;
        chk("rd_path", 32'(m_rd_bus), 32'(pat[i]) << m);
        tick();
      end
    end
    guard = 0;
    while (ph != PH_CLEAN && guard < 100) begin
      if (abort_after >= 0 && guard == abort_after) begin
        rst = 1'b1;
        m_master_valid[m] = 1'b0;
        tick();
        rst = 1'b0;
        chk("rst_grant", 32'(m_grant), 0);
        chk("rst_ack", 32'(m_ack), 0);
        chk("rst_s_valid", 32'(s_master_valid), 0);
        chk("rst_m_sready", 32'(m_slave_ready), 0);
        return;
      end
      m_master_valid[m] = 1'($urandom);
      tick();
      guard++;
    end
    chk("window_timeout", 32'(guard >= 100), 0);
    m_master_valid[m] = 1'b0;
    tick();
    chk("idle_grant", 32'(m_grant), 0);
  endtask

  initial begin
    rst = 1'b1;
    m_mode = '0; m_wr_bus = '0; m_master_valid = '0; m_master_ready = '0;
    s_rd_bus = '0; s_slave_ready = '0; s_slave_valid = '0;
    @(posedge clk);
    model_step();
    #1;
    tick();
    rst = 1'b0;
    chk("reset_grant", 32'(m_grant), 0);

    // M0 to slave 1, full 32-cycle window.
    run_xfer(0, 5'b01000, -1, 1'b0, -1);
    // Nak: sel 3 with three slaves.
    run_xfer(0, 5'b11000, -1, 1'b0, -1);
    // Stall of 3 cycles after the second address bit.
    run_xfer(0, 5'b01011, 2, 1'b0, -1);
    // Read path via slave 2 from M1.
    run_xfer(1, 5'b10000, -1, 1'b1, -1);
    // Reset in the middle of a connected window.
    run_xfer(1, 5'b01000, -1, 1'b0, 5);
    tick();
    // Both masters request from reset: M0, then M1, then M0 again.
    m_master_valid = 2'b11;
    run_xfer(0, 5'b00111, -1, 1'b0, -1);
    run_xfer(1, 5'b10101, -1, 1'b0, -1);
    m_master_valid[1] = 1'b1;
    run_xfer(0, 5'b01100, -1, 1'b0, -1);
    run_xfer(1, 5'b11111, -1, 1'b0, -1);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
